// File: rtl/axi3_ring_writer.sv
// axi3_ring_writer: drains a FWFT FIFO into a DDR ring buffer with single-outstanding AXI3 write bursts.
// Each burst is sized from FIFO level, the 4KB boundary and ring free space.
module axi3_ring_writer #(
  parameter int DATA_W = 32,
  parameter int ID_W = 6,
  parameter int MAX_BURST = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] WIN_BYTES = 32'h0100_0000,
  parameter int WRAP_MODE = 1,
  parameter int CNT_W = 11,
  localparam int PTR_W = $clog2(64'(WIN_BYTES) * 8 / DATA_W)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic [CNT_W-1:0]      fifo_rdcount,
  output logic                  fifo_rd,
  output logic [31:0]           m_axi_awaddr,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [3:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [3:0]            m_axi_awcache,
  output logic [1:0]            m_axi_awlock,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic [ID_W-1:0]       m_axi_wid,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [PTR_W-1:0]      host_rd_ptr,
  input  logic                  reset_addr,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic                  axi_busy,
  output logic                  overflow,
  output logic                  bresp_err
);
  localparam int LW = PTR_W + 1;
  localparam int B4K_W = $clog2(4096 * 8 / DATA_W);
  typedef enum logic [2:0] {IDLE, CALC, AW, W, B} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] id;
  logic [3:0] beat;
  logic [LW-1:0] free, cnt_sat, to_4k, len_a, len;
  logic unused_ok;

  // one slot stays empty in flow-controlled mode so full and empty stay distinguishable
  assign free = WRAP_MODE != 0 ? {1'b1, {PTR_W{1'b0}}} : {1'b0, {PTR_W{1'b1}}} - {1'b0, wr_ptr - host_rd_ptr};
  assign cnt_sat = fifo_rdcount > CNT_W'(MAX_BURST) ? LW'(MAX_BURST) : LW'(fifo_rdcount);
  assign to_4k = LW'(4096 * 8 / DATA_W) - LW'(wr_ptr[B4K_W-1:0]);
  assign len_a = cnt_sat < to_4k ? cnt_sat : to_4k;
  assign len = len_a < free ? len_a : free;

  assign m_axi_awsize = 3'($clog2(DATA_W / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awlock = 2'b00;
  assign m_axi_awprot = 3'b000;
  assign m_axi_awqos = 4'b0000;
  assign m_axi_awid = id;
  assign m_axi_wid = id;
  assign m_axi_wdata = fifo_data;
  assign m_axi_wstrb = '1;
  assign m_axi_bready = 1'b1;
  assign m_axi_awvalid = state == AW;
  assign m_axi_wvalid = state == W;
  assign m_axi_wlast = m_axi_wvalid && beat == m_axi_awlen;
  assign fifo_rd = m_axi_wvalid && m_axi_wready;
  assign axi_busy = state != IDLE;
  assign unused_ok = ^m_axi_bid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !reset_addr && fifo_rdcount != '0 && free != '0 ? CALC : IDLE;
      CALC: state_nx = AW;
      AW: state_nx = m_axi_awready ? W : AW;
      W: state_nx = fifo_rd && m_axi_wlast ? B : W;
      B: state_nx = m_axi_bvalid ? IDLE : B;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen <= '0;
      id <= '0;
      beat <= '0;
      overflow <= 1'b0;
      bresp_err <= 1'b0;
    end else begin
      if (state == IDLE && reset_addr) begin
        wr_ptr <= '0;
        overflow <= 1'b0;
        bresp_err <= 1'b0;
      end else if (state == IDLE && fifo_rdcount != '0 && free == '0) begin
        overflow <= 1'b1;
      end
      if (state == CALC) begin
        m_axi_awlen <= 4'(len - 1'b1);
        m_axi_awaddr <= BASE_ADDR + (32'(wr_ptr) << $clog2(DATA_W / 8));
        beat <= '0;
      end
      if (fifo_rd) begin
        wr_ptr <= wr_ptr + 1'b1;
        beat <= beat + 1'b1;
      end
      if (state == B && m_axi_bvalid) begin
        id <= id + 1'b1;
        if (m_axi_bresp != 2'b00) bresp_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi3_ring_writer.sv
// tb_axi3_ring_writer: scoreboard bench; dut0 overwrite-wraps on an 8 KB ring, dut1 is flow-controlled on a 4 KB ring.
// One FIFO model and AXI slave are shared; sel routes FIFO level and observed outputs to one DUT.
module tb_axi3_ring_writer;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] DBASE = 32'hD000_0000;
  typedef struct packed {logic [31:0] addr; logic [3:0] len; logic [5:0] id;} aw_t;

  logic clk = 0, rstn = 0, sel = 0, reset_addr = 0, awready = 1, wready = 1, bvalid = 0;
  logic [1:0] bresp = 0;
  logic [9:0] host_ptr = 0;
  int pushed = 0, popped = 0, exp_word = 0, beat_n = 0, lasts_seen = 0, b_sent = 0, err_at = -1;
  int vectors = 0, miscompares = 0;
  logic [3:0] cur_len = 0;
  logic [5:0] cur_id = 0;
  logic [5:0] nid [2];
  aw_t exp_q[$];
  logic [10:0] cnt;
  logic [31:0] fifo_data;
  assign cnt = 11'(pushed - popped);
  assign fifo_data = DBASE + 32'(popped);

  logic [31:0] awaddr0, awaddr1, wdata0, wdata1;
  logic [3:0] awlen0, awlen1, wstrb0, wstrb1, awcache0, awcache1, awqos0, awqos1;
  logic [5:0] awid0, awid1, wid0, wid1;
  logic [2:0] awsize0, awsize1, awprot0, awprot1;
  logic [1:0] awburst0, awburst1, awlock0, awlock1;
  logic awvalid0, awvalid1, wvalid0, wvalid1, wlast0, wlast1, fifo_rd0, fifo_rd1;
  logic busy0, busy1, ovf0, ovf1, berr0, berr1, bready0, bready1;
  logic [10:0] wrp0;
  logic [9:0] wrp1;

  axi3_ring_writer #(.WIN_BYTES(32'h2000), .WRAP_MODE(1)) dut0 (
    .clk(clk), .rstn(rstn), .fifo_data(fifo_data), .fifo_rdcount(sel ? 11'd0 : cnt), .fifo_rd(fifo_rd0),
    .m_axi_awaddr(awaddr0), .m_axi_awid(awid0), .m_axi_awlen(awlen0), .m_axi_awvalid(awvalid0),
    .m_axi_awready(awready), .m_axi_awsize(awsize0), .m_axi_awburst(awburst0), .m_axi_awcache(awcache0),
    .m_axi_awlock(awlock0), .m_axi_awprot(awprot0), .m_axi_awqos(awqos0), .m_axi_wdata(wdata0),
    .m_axi_wstrb(wstrb0), .m_axi_wid(wid0), .m_axi_wlast(wlast0), .m_axi_wvalid(wvalid0),
    .m_axi_wready(wready), .m_axi_bid(6'd0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready0), .host_rd_ptr(11'd0), .reset_addr(reset_addr), .wr_ptr(wrp0),
    .axi_busy(busy0), .overflow(ovf0), .bresp_err(berr0));

  axi3_ring_writer #(.WIN_BYTES(32'h1000), .WRAP_MODE(0)) dut1 (
    .clk(clk), .rstn(rstn), .fifo_data(fifo_data), .fifo_rdcount(sel ? cnt : 11'd0), .fifo_rd(fifo_rd1),
    .m_axi_awaddr(awaddr1), .m_axi_awid(awid1), .m_axi_awlen(awlen1), .m_axi_awvalid(awvalid1),
    .m_axi_awready(awready), .m_axi_awsize(awsize1), .m_axi_awburst(awburst1), .m_axi_awcache(awcache1),
    .m_axi_awlock(awlock1), .m_axi_awprot(awprot1), .m_axi_awqos(awqos1), .m_axi_wdata(wdata1),
    .m_axi_wstrb(wstrb1), .m_axi_wid(wid1), .m_axi_wlast(wlast1), .m_axi_wvalid(wvalid1),
    .m_axi_wready(wready), .m_axi_bid(6'd0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready1), .host_rd_ptr(host_ptr), .reset_addr(reset_addr), .wr_ptr(wrp1),
    .axi_busy(busy1), .overflow(ovf1), .bresp_err(berr1));

  wire [31:0] awaddr = sel ? awaddr1 : awaddr0;
  wire [31:0] wdata = sel ? wdata1 : wdata0;
  wire [3:0] awlen = sel ? awlen1 : awlen0;
  wire [5:0] awid = sel ? awid1 : awid0;
  wire [5:0] wid = sel ? wid1 : wid0;
  wire awvalid = sel ? awvalid1 : awvalid0;
  wire wvalid = sel ? wvalid1 : wvalid0;
  wire wlast = sel ? wlast1 : wlast0;
  wire fifo_rd = sel ? fifo_rd1 : fifo_rd0;
  wire busy = sel ? busy1 : busy0;
  wire ovf = sel ? ovf1 : ovf0;
  wire berr = sel ? berr1 : berr0;
  wire [10:0] wr_ptr = sel ? {1'b0, wrp1} : wrp0;

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int ptr, input int beats);
    exp_q.push_back(aw_t'{addr: BASE + 32'(ptr) * 4, len: 4'(beats - 1), id: nid[sel]});
    nid[sel] = nid[sel] + 6'd1;
  endtask

  // quiet = three idle cycles in a row; a DUT with work never idles more than one
  task automatic wait_quiet(input string nm);
    int q = 0, t = 0;
    while (q < 3 && t < 6000) begin
      @(negedge clk);
      q = busy ? 0 : q + 1;
      t++;
    end
    check({nm, "_timeout"}, 32'(q >= 3), 1);
    check({nm, "_bursts_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string p);
    check({p, "_awvalid"}, 32'(awvalid0), 0);
    check({p, "_wvalid"}, 32'(wvalid0), 0);
    check({p, "_wlast"}, 32'(wlast0), 0);
    check({p, "_fifo_rd"}, 32'(fifo_rd0), 0);
    check({p, "_busy"}, 32'(busy0), 0);
    check({p, "_wr_ptr"}, 32'(wrp0), 0);
    check({p, "_overflow"}, 32'(ovf0), 0);
    check({p, "_bresp_err"}, 32'(berr0), 0);
    check({p, "_awaddr"}, awaddr0, 0);
    check({p, "_awlen"}, 32'(awlen0), 0);
    check({p, "_awid"}, 32'(awid0), 0);
    check({p, "_wid"}, 32'(wid0), 0);
    check({p, "_bready"}, 32'(bready0), 1);
    check({p, "_awsize"}, 32'(awsize0), 2);
    check({p, "_awburst"}, 32'(awburst0), 1);
    check({p, "_awcache"}, 32'(awcache0), 3);
    check({p, "_awlock_prot_qos"}, {awlock0, awprot0, awqos0}, 0);
    check({p, "_wstrb"}, 32'(wstrb0), 32'hF);
  endtask

  always @(posedge clk) if (rstn && fifo_rd) popped <= popped + 1;

  // scoreboard monitor: AW handshakes pop the expected burst, W beats are checked against the FIFO stream
  always @(negedge clk) begin
    aw_t e;
    if (rstn) begin
      if (awvalid && awready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL aw_unexpected: got awaddr %h awlen %0d, required no burst", awaddr, awlen);
        end else begin
          e = exp_q.pop_front();
          check("awaddr", awaddr, e.addr);
          check("awlen", 32'(awlen), 32'(e.len));
          check("awid", 32'(awid), 32'(e.id));
          cur_len = e.len;
          cur_id = e.id;
          beat_n = 0;
        end
      end
      if (wvalid) begin
        check("wdata", wdata, DBASE + 32'(exp_word));
        if (wready) begin
          check("wlast", 32'(wlast), 32'(beat_n == int'(cur_len)));
          check("wid", 32'(wid), 32'(cur_id));
          check("fifo_rd", 32'(fifo_rd), 1);
          exp_word++;
          beat_n++;
          if (wlast) lasts_seen++;
        end else begin
          check("fifo_rd_stall", 32'(fifo_rd), 0);
        end
      end
    end
  end

  initial forever begin
    tick();
    bvalid = 0;
    bresp = 2'b00;
    if (rstn && lasts_seen > b_sent) begin
      bvalid = 1;
      bresp = b_sent == err_at ? 2'b10 : 2'b00;
      b_sent++;
    end
  end

  initial begin
    int p0, ps, t;
    nid[0] = 0;
    nid[1] = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    check_reset("por");
    // bursts 16,16,8 with an error response on the second
    err_at = 1;
    expect_burst(0, 16);
    expect_burst(16, 16);
    expect_burst(32, 8);
    pushed += 40;
    wait_quiet("t1");
    check("t1_wr_ptr", 32'(wr_ptr), 40);
    check("t1_bresp_err", 32'(berr), 1);
    check("t1_next_id", 32'(awid), 3);
    // advance to 1020, then 10 words must split at the 4 KB line
    for (int k = 0; k < 61; k++) expect_burst(40 + 16 * k, 16);
    expect_burst(1016, 4);
    pushed += 980;
    wait_quiet("t2a");
    check("t2_preset_ptr", 32'(wr_ptr), 1020);
    check("t2_id_wrapped", 32'(awid), 1);
    expect_burst(1020, 4);
    expect_burst(1024, 6);
    pushed += 10;
    wait_quiet("t2b");
    check("t2_wr_ptr", 32'(wr_ptr), 1030);
    check("t2_bresp_err_sticky", 32'(berr), 1);
    // reset_addr held while data waits: no burst may start
    tick();
    reset_addr = 1;
    pushed += 2040;
    repeat (3) begin
      @(negedge clk);
      check("t5_reset_addr_prio", 32'(busy), 0);
    end
    check("t5_wr_ptr", 32'(wr_ptr), 0);
    check("t5_bresp_err", 32'(berr), 0);
    check("t5_overflow", 32'(ovf), 0);
    for (int k = 0; k < 127; k++) expect_burst(16 * k, 16);
    expect_burst(2032, 8);
    tick();
    reset_addr = 0;
    wait_quiet("t3a");
    check("t3_preset_ptr", 32'(wr_ptr), 2040);
    expect_burst(2040, 8);
    expect_burst(0, 8);
    pushed += 16;
    wait_quiet("t3b");
    check("t3_wr_ptr", 32'(wr_ptr), 8);
    check("t3_wrap_no_overflow", 32'(ovf0), 0);
    // flow-controlled ring: stops one short of full
    tick();
    sel = 1;
    for (int k = 0; k < 63; k++) expect_burst(16 * k, 16);
    expect_burst(1008, 15);
    pushed += 1100;
    wait_quiet("t4a");
    check("t4_wr_ptr_full", 32'(wr_ptr), 1023);
    check("t4_overflow", 32'(ovf), 1);
    check("t4_fifo_left", 32'(pushed - popped), 77);
    expect_burst(1023, 1);
    expect_burst(0, 15);
    tick();
    host_ptr = 16;
    wait_quiet("t4b");
    check("t4_wr_ptr_resume", 32'(wr_ptr), 15);
    check("t4_overflow_sticky", 32'(ovf), 1);
    check("t4_fifo_left2", 32'(pushed - popped), 61);
    // W stall then reset mid-burst
    tick();
    pushed = popped;
    sel = 0;
    expect_burst(8, 16);
    p0 = popped;
    pushed += 16;
    t = 0;
    while (popped < p0 + 3 && t < 200) begin
      tick();
      t++;
    end
    check("t6_reach_beat3", 32'(popped - p0), 3);
    wready = 0;
    ps = popped;
    repeat (5) tick();
    check("t6_no_pop_stall", 32'(popped), 32'(ps));
    check("t6_busy_stall", 32'(busy), 1);
    wready = 1;
    repeat (2) tick();
    wready = 0;
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    exp_q.delete();
    pushed = popped;
    nid[0] = 0;
    nid[1] = 0;
    wready = 1;
    @(negedge clk);
    check_reset("t6");
    expect_burst(0, 4);
    tick();
    pushed += 4;
    wait_quiet("t6b");
    check("t6_post_reset_ptr", 32'(wr_ptr), 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
